wait_event_multi_ch: RTL
========================

# wait_event_multi_ch

Synthesizable multi-channel event waiter: the parametrised successor of the single-purpose wait-event block used by the testbench sequencer. It monitors `G_NB_CH` one-bit signals and executes one wait command at a time. Each command selects a channel, an event mode (edge or level), an occurrence count and an optional timeout. On completion it reports done, error flags, elapsed cycles and occurrences seen, so a sequencer or an on-chip test controller can sequence on DUT events without behavioural delays.

## Interface
Parameters:
- `G_NB_CH`, default 8: number of monitored channels, 1..256.
- `G_SEL_WIDTH`, default 3: width of `ch_sel`; must be ≥ clog2(`G_NB_CH`), minimum 1.
- `G_CNT_WIDTH`, default 16: width of the occurrence counters.
- `G_TO_WIDTH`, default 32: width of the timeout and elapsed counters.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: command strobe; accepted only when `busy`=0.
- `ch_sel`, in, `G_SEL_WIDTH`: channel index, sampled at `start`.
- `mode`, in, 3: 000 rise, 001 fall, 010 any edge, 011 level high, 100 level low; 101–111 illegal.
- `occ_nb`, in, `G_CNT_WIDTH`: number of edges required; 0 is treated as 1; ignored in level modes.
- `timeout`, in, `G_TO_WIDTH`: maximum number of wait cycles; 0 means no timeout.
- `abort`, in, 1: cancels the active command.
- `wait_signals`, in, `G_NB_CH`: monitored signals, already synchronous to `clk`.
- `busy`, out, 1: a command is active.
- `done`, out, 1: one-cycle completion pulse.
- `timeout_err`, out, 1: last command ended by timeout.
- `cmd_err`, out, 1: last command was illegal.
- `elapsed`, out, `G_TO_WIDTH`: number of WAIT cycles used by the last or current command.
- `occ_seen`, out, `G_CNT_WIDTH`: number of matching edges counted.

## Operation
- `prev[G_NB_CH]` registers `wait_signals` every cycle, in every state. It resets to 0.
- Edge detection at cycle t:
  - rise = sig & ~prev
  - fall = ~sig & prev
  - any = sig ^ prev
- FSM states: IDLE, WAIT, DONE.
- IDLE, on `start`:
  - Latch `ch_sel`, `mode`, max(`occ_nb`,1) and `timeout`.
  - Clear `elapsed`, `occ_seen`, `timeout_err` and `cmd_err`.
  - Set `busy`.
  - If the command is illegal (mode 101–111, or `ch_sel` ≥ `G_NB_CH`): set `cmd_err`, go to DONE.
  - Otherwise go to WAIT.
- WAIT, evaluated every cycle:
  - Increment `elapsed`; it saturates at all-ones.
  - Edge modes: increment `occ_seen` on each matching edge. The match condition is `occ_seen`+1 = target.
  - Level modes: the match condition is the selected signal at the required level in this cycle.
  - Timeout condition: `timeout`≠0 and `elapsed`+1 = `timeout`.
  - Match: go to DONE.
  - Timeout without match: set `timeout_err`, go to DONE.
  - Match and timeout in the same cycle: the match wins and `timeout_err` stays 0.
- DONE: assert `done` for one cycle, clear `busy`, return to IDLE.
- `abort` in WAIT or DONE: go to IDLE, clear `busy`, suppress `done`. `elapsed` and `occ_seen` hold their values; the error flags stay cleared.
- `abort` and `start` together in IDLE: `start` is accepted and `abort` is ignored.
- `start` while `busy`=1 is ignored; it is not queued.
- `timeout_err`, `cmd_err`, `elapsed` and `occ_seen` hold their values until the next accepted `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `timeout_err`=0, `cmd_err`=0, `elapsed`=0, `occ_seen`=0, `prev`=0, FSM in IDLE.
- `start` is sampled at edge T0. `busy`=1 from T0+1.
- The first evaluated cycle is T0+1. An edge present in the T0 cycle is not counted.
- Match evaluated in cycle Tm:
  - FSM enters DONE at Tm+1.
  - `done`=1 during Tm+1.
  - `busy`=0 from Tm+2.
- Minimum latency from `start` to `done` is 2 cycles (level already true, or an illegal command).
- Timeout N: the last evaluated cycle is T0+N. `done` is asserted in T0+N+1 with `elapsed`=N.
- Back-to-back commands: the next `start` is accepted in the cycle `busy` returns to 0.
- Reset asserted mid-command: all outputs return to their reset values immediately and asynchronously. No `done` is produced.

## Test plan
- Rise count: ch 2, mode 000, `occ_nb`=3, `timeout`=0; drive 3 pulses spaced 5 cycles apart. Expect: one `done` pulse, `occ_seen`=3, `timeout_err`=0.
- Timeout: ch 0, mode 001, `occ_nb`=1, `timeout`=10; channel held constant. Expect: `done` 11 cycles after `start`, `elapsed`=10, `timeout_err`=1.
- Level already satisfied: ch 7 held high, mode 011. Expect: `done` exactly 2 cycles after `start`, `elapsed`=1.
- Illegal commands: mode 110, then `ch_sel`=9 with `G_NB_CH`=8 and `G_SEL_WIDTH`=4. Expect for each: `cmd_err`=1 and `done` 2 cycles after `start`.
- Match/timeout collision and abort:
  - Rise occurs in the same cycle the timeout expires. Expect: `timeout_err`=0.
  - Separate command with `abort` asserted in WAIT. Expect: no `done`, `busy`=0 next cycle; a new `start` is accepted immediately.
- Async reset at cycle 4 of a 20-cycle wait. Expect: all outputs 0 within the reset cycle; no `done` after reset is released.

Source files
------------

// File: rtl/wait_event_multi_ch.sv
// Multi-channel event waiter: runs one wait command at a time on a selected channel
// (edge count or level) with optional timeout, and reports done, error flags and counters.
module wait_event_multi_ch #(
  parameter int G_NB_CH     = 8,
  parameter int G_SEL_WIDTH = 3,
  parameter int G_CNT_WIDTH = 16,
  parameter int G_TO_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [G_SEL_WIDTH-1:0] ch_sel,
  input  logic [2:0]             mode,
  input  logic [G_CNT_WIDTH-1:0] occ_nb,
  input  logic [G_TO_WIDTH-1:0]  timeout,
  input  logic                   abort,
  input  logic [G_NB_CH-1:0]     wait_signals,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic                   cmd_err,
  output logic [G_TO_WIDTH-1:0]  elapsed,
  output logic [G_CNT_WIDTH-1:0] occ_seen
);

  localparam int PAD_W = 1 << G_SEL_WIDTH;

  localparam logic [2:0] MODE_RISE = 3'b000;
  localparam logic [2:0] MODE_FALL = 3'b001;
  localparam logic [2:0] MODE_ANY  = 3'b010;
  localparam logic [2:0] MODE_HIGH = 3'b011;
  localparam logic [2:0] MODE_LOW  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [G_NB_CH-1:0]     prev_q;
  logic [G_SEL_WIDTH-1:0] ch_q, ch_d;
  logic [2:0]             mode_q, mode_d;
  logic [G_CNT_WIDTH-1:0] target_q, target_d;
  logic [G_CNT_WIDTH-1:0] occ_q, occ_d;
  logic [G_TO_WIDTH-1:0]  tmo_q, tmo_d;
  logic [G_TO_WIDTH-1:0]  elapsed_q, elapsed_d;
  logic                   terr_q, terr_d;
  logic                   cerr_q, cerr_d;

  logic [PAD_W-1:0]       sig_pad, prev_pad;
  logic                   cur_sig, prev_sig;
  logic                   edge_hit, match, tmo_hit, cmd_legal;
  logic [G_CNT_WIDTH-1:0] occ_inc;
  logic [G_TO_WIDTH-1:0]  elapsed_inc;

  // Pad the channel vectors to the full select range so any ch_sel value indexes safely.
  always_comb begin
    sig_pad                 = '0;
    prev_pad                = '0;
    sig_pad[G_NB_CH-1:0]    = wait_signals;
    prev_pad[G_NB_CH-1:0]   = prev_q;
  end

  assign occ_inc     = occ_q + G_CNT_WIDTH'(1);
  assign elapsed_inc = elapsed_q + G_TO_WIDTH'(1);
  assign tmo_hit     = (tmo_q != '0) && (elapsed_inc == tmo_q);
  assign cmd_legal   = (mode <= MODE_LOW) &&
                       ({1'b0, ch_sel} < (G_SEL_WIDTH + 1)'(G_NB_CH));

  always_comb begin
    cur_sig  = sig_pad[ch_q];
    prev_sig = prev_pad[ch_q];
    edge_hit = 1'b0;
    match    = 1'b0;
    case (mode_q)
      MODE_RISE: edge_hit = cur_sig & ~prev_sig;
      MODE_FALL: edge_hit = ~cur_sig & prev_sig;
      MODE_ANY:  edge_hit = cur_sig ^ prev_sig;
      default:   edge_hit = 1'b0;
    endcase
    case (mode_q)
      MODE_HIGH: match = cur_sig;
      MODE_LOW:  match = ~cur_sig;
      default:   match = edge_hit && (occ_inc == target_q);
    endcase
  end

  // An illegal command still passes through WAIT for one cycle without evaluating,
  // so every command reports done no earlier than two cycles after start.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    mode_d    = mode_q;
    target_d  = target_q;
    tmo_d     = tmo_q;
    elapsed_d = elapsed_q;
    occ_d     = occ_q;
    terr_d    = terr_q;
    cerr_d    = cerr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ch_d      = ch_sel;
          mode_d    = mode;
          target_d  = (occ_nb == '0) ? G_CNT_WIDTH'(1) : occ_nb;
          tmo_d     = timeout;
          elapsed_d = '0;
          occ_d     = '0;
          terr_d    = 1'b0;
          cerr_d    = ~cmd_legal;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          terr_d  = 1'b0;
          cerr_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cerr_q) begin
          state_d = ST_DONE;
        end else begin
          if (elapsed_q != '1) elapsed_d = elapsed_inc;
          if (edge_hit) occ_d = occ_inc;
          if (match) begin
            state_d = ST_DONE;
          end else if (tmo_hit) begin
            terr_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) begin
          terr_d = 1'b0;
          cerr_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= wait_signals;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      mode_q    <= '0;
      target_q  <= '0;
      tmo_q     <= '0;
      elapsed_q <= '0;
      occ_q     <= '0;
      terr_q    <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      tmo_q     <= tmo_d;
      elapsed_q <= elapsed_d;
      occ_q     <= occ_d;
      terr_q    <= terr_d;
      cerr_q    <= cerr_d;
    end
  end

  // Abort during the DONE cycle swallows the pulse in that same cycle.
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE) && !abort;
  assign timeout_err = terr_q;
  assign cmd_err     = cerr_q;
  assign elapsed     = elapsed_q;
  assign occ_seen    = occ_q;

endmodule
